// File: rtl/reg_file_if.sv
// reg_file_if: read/write bus between a register file and its user (ALU datapath)
interface reg_file_if #(parameter int ADDR_W = 5, parameter int DATA_W = 32);
   logic [ADDR_W-1:0] R_Addr_A;
   logic [ADDR_W-1:0] R_Addr_B;
   logic [ADDR_W-1:0] W_Addr;
   logic Write_Reg;
   logic [DATA_W-1:0] W_Data;
   logic [DATA_W-1:0] R_Data_A;
   logic [DATA_W-1:0] R_Data_B;
   logic W_Busy;
   modport master (
      output R_Addr_A, R_Addr_B, W_Addr, Write_Reg, W_Data,
      input R_Data_A, R_Data_B, W_Busy
   );
   modport slave (
      input R_Addr_A, R_Addr_B, W_Addr, Write_Reg, W_Data,
      output R_Data_A, R_Data_B, W_Busy
   );
endinterface

// File: rtl/reg_file.sv
// reg_file: 2-read/1-write register file, R0 hardwired to 0, post-reset clear FSM; REGFILE_BYPASS_EN adds write-to-read forwarding
module reg_file #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 32
) (
   input logic clk,
   input logic rst_n,
   reg_file_if.slave bus
);
   typedef enum logic {CLEAR, IDLE} state_t;
   state_t r_state;
   logic [ADDR_W-1:0] r_cnt;
   logic r_busy;
   logic [DATA_W-1:0] r_mem [2**ADDR_W];
   logic w_we;
   logic w_hit_a;
   logic w_hit_b;
   assign w_we = bus.Write_Reg && !r_busy && bus.W_Addr != '0;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_state <= CLEAR;
         r_cnt <= ADDR_W'(1);
         r_busy <= 1'b1;
      end else if (r_state == CLEAR) begin
         r_cnt <= r_cnt + 1'b1;
         if (r_cnt == '1) begin
            r_state <= IDLE;
            r_busy <= 1'b0;
         end
      end
   // the array has no reset; only the clear sequence zeroes it
   always_ff @(posedge clk)
      if (r_busy) r_mem[r_cnt] <= '0;
      else if (w_we) r_mem[bus.W_Addr] <= bus.W_Data;
`ifdef REGFILE_BYPASS_EN
   assign w_hit_a = w_we && bus.W_Addr == bus.R_Addr_A;
   assign w_hit_b = w_we && bus.W_Addr == bus.R_Addr_B;
`else
   assign w_hit_a = 1'b0;
   assign w_hit_b = 1'b0;
`endif
   assign bus.R_Data_A = (r_busy || bus.R_Addr_A == '0) ? '0 : w_hit_a ? bus.W_Data : r_mem[bus.R_Addr_A];
   assign bus.R_Data_B = (r_busy || bus.R_Addr_B == '0) ? '0 : w_hit_b ? bus.W_Data : r_mem[bus.R_Addr_B];
   assign bus.W_Busy = r_busy;
endmodule
